// File: rtl/arm9_dbus_pkg.sv
// arm9_dbus_pkg: shared address map, STATUS bit positions and UART TX states
package arm9_dbus_pkg;
  localparam logic [31:0] DBUS_STATUS_ADDR = 32'hE000_0000;
  localparam logic [31:0] DBUS_TXDATA_ADDR = 32'hE000_0004;
  localparam logic [3:0]  DBUS_RAM_REGION  = 4'h4;
  localparam int STATUS_FULL_BIT = 0;
  localparam int STATUS_BUSY_BIT = 1;
  localparam int STATUS_OVF_BIT  = 2;
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;
endpackage

// File: rtl/dbus_sync_fifo.sv
// dbus_sync_fifo: single-clock FIFO with show-ahead read data
//   push_i/din_i  write side; a push while full is dropped
//   pop_i/dout_o  read side; dout_o is the head entry, a pop while empty is ignored
//   full_o/empty_o/count_o  occupancy taken from the registered count
module dbus_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/arm9_dbus_responder.sv
// arm9_dbus_responder: data-bus far end with byte-maskable SRAM, console STATUS/TXDATA and 8N1 UART
//   clk, rst                      clock, synchronous active-high reset
//   ram_cen/ram_wen/ram_flag      access strobe, write select, write byte enables
//   ram_addr/ram_wdata            byte address, write data
//   ram_rdata                     registered read data (latency 1, held between reads)
//   uart_txd                      serial transmit line, idle high
module arm9_dbus_responder
  import arm9_dbus_pkg::*;
#(
  parameter int RAM_AW     = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_DIV   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_cen,
  input  logic        ram_wen,
  input  logic [3:0]  ram_flag,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_wdata,
  output logic [31:0] ram_rdata,
  output logic        uart_txd
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  logic [31:0] sram_q [2**RAM_AW];
  logic [RAM_AW-1:0] idx;
  logic sel_ram, sel_st, sel_tx, rd_en, wr_en, push, status_rd;
  logic [31:0] status, rdata_q;
  logic ovf_q, ovf_d, busy, full, empty, pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic [7:0] fifo_dout, shift_q, shift_d;
  tx_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic txd_q, txd_d, baud_end;
  assign idx       = ram_addr[RAM_AW+1:2];
  assign sel_ram   = ram_addr[31:28] == DBUS_RAM_REGION;
  assign sel_st    = ram_addr == DBUS_STATUS_ADDR;
  assign sel_tx    = ram_addr == DBUS_TXDATA_ADDR;
  assign rd_en     = ram_cen & ~ram_wen;
  assign wr_en     = ram_cen & ram_wen;
  assign push      = wr_en & sel_tx & ram_flag[0];
  assign status_rd = rd_en & sel_st;
  assign full      = fifo_cnt == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH);
  assign busy      = (fifo_cnt != '0) | (state_q != TX_IDLE);
  assign ram_rdata = rdata_q;
  assign uart_txd  = txd_q;
  always_comb begin
    status = '0;
    status[STATUS_FULL_BIT] = full;
    status[STATUS_BUSY_BIT] = busy;
    status[STATUS_OVF_BIT]  = ovf_q;
  end
  // a push that overflows must win over a simultaneous clearing STATUS read
  assign ovf_d = (push & full) ? 1'b1 : status_rd ? 1'b0 : ovf_q;
  always_ff @(posedge clk) begin
    if (wr_en & sel_ram)
      for (int i = 0; i < 4; i++)
        if (ram_flag[i]) sram_q[idx][8*i +: 8] <= ram_wdata[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (rd_en) rdata_q <= sel_ram ? sram_q[idx] : sel_st ? status : '0;
      ovf_q <= ovf_d;
    end
  end
  dbus_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (ram_wdata[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );
  assign baud_end = baud_q == BAUD_LAST;
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == TX_IDLE || baud_end) ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    case (state_q)
      TX_IDLE:
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = TX_START;
        end
      TX_START: begin
        txd_d = 1'b0;
        if (baud_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        txd_d = shift_q[0];
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = TX_STOP;
        end
      end
      TX_STOP:
        if (baud_end) begin
          // chain straight into the next frame so queued bytes go out gap-free
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = TX_START;
          end else state_d = TX_IDLE;
        end
      default: state_d = TX_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end
endmodule

// File: doc/arm9_dbus_responder.md
# arm9_dbus_responder

Synthesizable data-bus responder for `arm9_compatiable_code`, sitting on the core's `ram_*` port as the far end of the CPU's data accesses. Provides a byte-maskable word SRAM at 0x4xxxxxxx, a console status register at 0xE0000000, and a console TX data register at 0xE0000004. Writes to the TX data register feed a FIFO drained by an 8N1 UART transmitter. Replaces the behavioural memory/console model so the same software runs on FPGA.

## Interface
- `RAM_AW`, 12: SRAM word-address width (4096 words = 16 KiB).
- `FIFO_DEPTH`, 16: TX FIFO entries; power of two, ≥2.
- `BAUD_DIV`, 16: clocks per UART bit; ≥2.

- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ram_cen`  in  1  access strobe from core.
- `ram_wen`  in  1  1 = write, 0 = read (qualified by `ram_cen`).
- `ram_flag`  in  4  byte enables for writes; bit n enables `ram_wdata[8n+7:8n]`.
- `ram_addr`  in  32  byte address; bits [1:0] ignored.
- `ram_wdata`  in  32  write data.
- `ram_rdata`  out  32  registered read data.
- `uart_txd`  out  1  serial TX line, idle high.

## Operation
- Decode, per cycle with `ram_cen`=1:
  - `ram_addr[31:28]`==4'h4: SRAM, word index `ram_addr[RAM_AW+1:2]`; upper bits alias.
  - ==32'hE0000000: STATUS. Read value {29'b0, ovf, busy, full}. Writes ignored.
  - ==32'hE0000004: TXDATA. Write with `ram_flag[0]`=1 pushes `ram_wdata[7:0]`. Reads return 0.
  - Any other address: reads return 0, writes ignored.
- SRAM write: each byte lane updated only where its `ram_flag` bit is 1; `ram_flag`=4'b0000 leaves the word unchanged. SRAM contents are not reset.
- STATUS bits: `full` = FIFO count == FIFO_DEPTH; `busy` = FIFO non-empty or transmitter not IDLE; `ovf` = sticky, set when a push arrives while full. The pushed byte is then dropped. `ovf` is cleared by a STATUS read; the returned value still shows 1. If a set and a clear fall in the same cycle, set wins.
- FIFO: `full` is evaluated from the count at the start of the cycle, so a push while full is dropped even if a pop occurs in the same cycle. A simultaneous push and pop when not full leaves the count unchanged.
- UART TX FSM states:
  - IDLE: `uart_txd`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `uart_txd`=0 for BAUD_DIV clocks.
  - DATA: 8 bits, LSB first, BAUD_DIV clocks each.
  - STOP: `uart_txd`=1 for BAUD_DIV clocks. Then, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Bit counter is 3 bits; baud counter is $clog2(BAUD_DIV) bits and wraps at BAUD_DIV-1.

## Timing
- Read latency is 1: data for a read sampled at edge N appears on `ram_rdata` after edge N and holds until the next read. Writes and idle cycles do not change `ram_rdata`.
- SRAM read-after-write: a read one cycle after a write to the same word returns the merged new value. A read and write cannot occur in the same cycle.
- Push at edge N: STATUS read at N+1 reflects the new count. If the transmitter is IDLE, the pop happens at edge N+1 and `uart_txd` falls after edge N+2.
- One frame lasts 10·BAUD_DIV clocks; back-to-back frames are contiguous.
- Reset values: `ram_rdata`=0, `uart_txd`=1, FSM=IDLE, FIFO empty, `ovf`=0, counters 0.
- Reset mid-frame: `uart_txd` returns to 1 on the cycle after the reset edge, and FIFO contents are discarded.

## Structure
- Package `arm9_dbus_pkg`: address constants (`DBUS_STATUS_ADDR`, `DBUS_TXDATA_ADDR`, `DBUS_RAM_REGION`=4'h4), STATUS bit indices, UART FSM state enum.
- Sub-module `dbus_sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count). The top level holds decode, SRAM array, STATUS logic and the UART FSM.

## Test plan
- Write 0xDEADBEEF to 0x40000010 with flag 4'hF, then write 0x000000AA with flag 4'h1, then read → `ram_rdata`=0xDEADBEAA one cycle after the read.
- Write with flag 4'h0, then read → word unchanged; a read of 0x50000000 or 0x00000000 → 0.
- Push 0x41 with BAUD_DIV=4 → `uart_txd` low at push+2 cycles, then bits 1,0,0,0,0,0,1,0, then stop bit; STATUS.busy=1 for the whole frame and 0 after.
- Push 3 bytes back-to-back → three contiguous frames of 40 clocks each with no idle high beyond the stop bits.
- With the UART stalled by a large BAUD_DIV, push FIFO_DEPTH+2 bytes → STATUS=0x7. The next STATUS read returns ovf=0, and only FIFO_DEPTH+1 bytes are transmitted (one popped immediately, FIFO_DEPTH queued).
- Assert `rst` for 1 cycle mid-DATA → `uart_txd`=1 and STATUS=0 the next cycle; previously written SRAM word still reads back intact.
